// File: rtl/keccak_dma_pkg.sv
// Constants and FSM encoding for the Keccak OBI DMA.
//   KeccakNWords : 32-bit words per Keccak-f[1600] state
//   KeccakStateW : state width in bits
//   KeccakIdxW   : width of the word index counter
package keccak_dma_pkg;

    localparam int unsigned KeccakNWords = 50;
    localparam int unsigned KeccakStateW = 1600;
    localparam int unsigned KeccakIdxW   = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT_K  = 3'd4,
        ST_WR_REQ  = 3'd5,
        ST_WR_WAIT = 3'd6,
        ST_DONE    = 3'd7
    } keccak_dma_state_e;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by initiators and targets in this slice.
//   obi_req_t  : req, addr, we, be, wdata   (initiator -> target)
//   obi_resp_t : gnt, rvalid, rdata         (target -> initiator)
package obi_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;

    typedef struct packed {
        logic                    req;
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [3:0]              be;
        logic [ObiDataWidth-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [ObiDataWidth-1:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/keccak_obi_dma.sv
// OBI initiator that loads a Keccak-f[1600] state from memory, runs the
// permutation core once and stores the result back to memory.
//
// Ports:
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   start_i            : command strobe, only looked at in IDLE
//   src_addr_i         : source base address (bits [1:0] dropped)
//   dst_addr_i         : destination base address (bits [1:0] dropped)
//   busy_o             : high whenever not IDLE
//   done_o             : one-cycle pulse after the last write response
//   master_req_o       : OBI request (registered)
//   master_resp_i      : OBI response
//   keccak_din_o       : assembled state, word i at bits [32i+31:32i]
//   keccak_start_o     : one-cycle start pulse to the core
//   keccak_done_i      : core completion, level or pulse
//   keccak_dout_i      : permuted state, same word mapping
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for start_i
// ST_RD_REQ  | read request for word idx outstanding until gnt
// ST_RD_WAIT | waiting for read rvalid, then store into din
// ST_START   | keccak_start_o high for this cycle
// ST_WAIT_K  | waiting for keccak_done_i, capture dout
// ST_WR_REQ  | write request for word idx outstanding until gnt
// ST_WR_WAIT | waiting for write response
// ST_DONE    | done_o high for this cycle
module keccak_obi_dma
    import obi_pkg::*;
    import keccak_dma_pkg::*;
#(
    parameter int unsigned NWords    = KeccakNWords,
    parameter int unsigned AddrWidth = ObiAddrWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   src_addr_i,
    input  logic [AddrWidth-1:0]   dst_addr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output obi_req_t               master_req_o,
    input  obi_resp_t              master_resp_i,
    output logic [NWords*32-1:0]   keccak_din_o,
    output logic                   keccak_start_o,
    input  logic                   keccak_done_i,
    input  logic [NWords*32-1:0]   keccak_dout_i
);

    localparam int unsigned StateW = NWords * 32;
    localparam logic [KeccakIdxW-1:0] IdxLast = KeccakIdxW'(NWords - 1);
    localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);

    keccak_dma_state_e state_q, state_d;
    logic [KeccakIdxW-1:0] idx_q, idx_d, idx_inc;
    logic [AddrWidth-1:0]  src_q, src_d, dst_q, dst_d;
    logic [StateW-1:0]     din_q, din_d, res_q, res_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d, done_q, done_d, kstart_q, kstart_d;

    assign idx_inc = idx_q + KeccakIdxW'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        src_d    = src_q;
        dst_d    = dst_q;
        din_d    = din_q;
        res_d    = res_q;
        req_d    = 1'b0;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i & WordMask;
                    dst_d   = dst_addr_i & WordMask;
                    idx_d   = '0;
                    state_d = ST_RD_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    addr_d  = src_addr_i & WordMask;
                end
            end
            ST_RD_REQ: begin
                // request fields are held untouched until the grant
                req_d = 1'b1;
                if (master_resp_i.gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (master_resp_i.rvalid) begin
                    din_d[{idx_q, 5'd0} +: 32] = master_resp_i.rdata;
                    if (idx_q == IdxLast) begin
                        state_d = ST_START;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = ST_RD_REQ;
                        req_d   = 1'b1;
                        addr_d  = src_q + AddrWidth'({idx_inc, 2'b00});
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_K;
            end
            ST_WAIT_K: begin
                if (keccak_done_i) begin
                    res_d   = keccak_dout_i;
                    idx_d   = '0;
                    state_d = ST_WR_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    be_d    = 4'hF;
                    addr_d  = dst_q;
                    // res_q is loaded on this same edge, so take word 0 from the core
                    wdata_d = keccak_dout_i[31:0];
                end
            end
            ST_WR_REQ: begin
                req_d = 1'b1;
                if (master_resp_i.gnt) begin
                    req_d   = 1'b0;
                    state_d = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (master_resp_i.rvalid) begin
                    if (idx_q == IdxLast) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = ST_WR_REQ;
                        req_d   = 1'b1;
                        addr_d  = dst_q + AddrWidth'({idx_inc, 2'b00});
                        wdata_d = res_q[{idx_inc, 5'd0} +: 32];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // status outputs are registered from the next state
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        kstart_d = (state_d == ST_START);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            din_q    <= '0;
            res_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            kstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            din_q    <= din_d;
            res_q    <= res_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            kstart_q <= kstart_d;
        end
    end

    always_comb begin
        master_req_o       = '0;
        master_req_o.req   = req_q;
        master_req_o.addr  = addr_q;
        master_req_o.we    = we_q;
        master_req_o.be    = be_q;
        master_req_o.wdata = wdata_q;
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign keccak_start_o = kstart_q;
    assign keccak_din_o   = din_q;

endmodule
